// File: rtl/entropy_ac_scan_sequencer.sv
// Drives the AC run/level encoders for one slice: reads coefficients in ProRes
// AC order (scan position outer, block inner) and lines valid/last up with the encoders.
module entropy_ac_scan_sequencer #(
  parameter int BLOCKS_MAX = 8,
  parameter int COEFF_W    = 32,
  parameter int ADDR_W     = 9,
  parameter int ENC_LAT    = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [3:0]         num_blocks_i,
  output logic               rd_en_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  input  logic [COEFF_W-1:0] rd_data_i,
  output logic               enc_clr_o,
  output logic [COEFF_W-1:0] coeff_out_o,
  output logic               coeff_valid_o,
  output logic               coeff_last_o,
  output logic               bits_valid_o,
  output logic               bits_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         state_o
);

  // All interfaces are valid-only, with no ready: rd_data_i is taken exactly one
  // clock after rd_en_o, and consumers accept every beat while coeff_valid_o or
  // bits_valid_o is high.

  localparam int BLK_W = (BLOCKS_MAX > 1) ? $clog2(BLOCKS_MAX) : 1;
  localparam int CNT_W = $clog2(ENC_LAT + 1);

  localparam logic [5:0] SCAN [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  logic [BLK_W-1:0]   blk_q, last_blk_q;
  logic [5:0]         pos_q;
  logic [CNT_W-1:0]   drain_q;
  logic               rd_en_q, enc_clr_q, busy_q, done_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               coeff_valid_q, coeff_last_q;
  logic [ENC_LAT-1:0] bv_q, bl_q;

  logic [3:0]       n_clamp;
  logic             blk_wrap, term;
  logic [BLK_W-1:0] blk_d;
  logic [5:0]       pos_d;

  assign n_clamp  = (int'(num_blocks_i) > BLOCKS_MAX) ? 4'(BLOCKS_MAX) : num_blocks_i;
  assign blk_wrap = (blk_q == last_blk_q);
  assign term     = blk_wrap && (pos_q == 6'd63);
  assign blk_d    = blk_wrap ? '0 : blk_q + 1'b1;
  assign pos_d    = pos_q + 6'(blk_wrap);

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [BLK_W-1:0] b,
                                                input logic [5:0] p);
    return ADDR_W'({b, SCAN[p]});
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      blk_q         <= '0;
      last_blk_q    <= '0;
      pos_q         <= '0;
      drain_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      enc_clr_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      coeff_valid_q <= 1'b0;
      coeff_last_q  <= 1'b0;
      bv_q          <= '0;
      bl_q          <= '0;
    end else begin
      enc_clr_q     <= 1'b0;
      done_q        <= 1'b0;
      coeff_valid_q <= rd_en_q;
      coeff_last_q  <= rd_en_q & term;
      bv_q          <= {bv_q[ENC_LAT-2:0], coeff_valid_q};
      bl_q          <= {bl_q[ENC_LAT-2:0], coeff_last_q};

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_CLR;
            enc_clr_q  <= 1'b1;
            busy_q     <= 1'b1;
            blk_q      <= '0;
            pos_q      <= 6'd1;
            last_blk_q <= BLK_W'(n_clamp - 4'd1);
            rd_en_q    <= (n_clamp != 4'd0);
            rd_addr_q  <= mk_addr('0, 6'd1);
          end
        end
        S_CLR: begin
          if (rd_en_q) begin
            state_q   <= S_RUN;
            blk_q     <= blk_d;
            pos_q     <= pos_d;
            rd_addr_q <= mk_addr(blk_d, pos_d);
          end else begin
            // Empty slice: no coefficient is in flight, so one fewer drain cycle.
            state_q <= S_DRAIN;
            drain_q <= CNT_W'(ENC_LAT - 1);
          end
        end
        S_RUN: begin
          if (term) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= CNT_W'(ENC_LAT);
          end else begin
            blk_q     <= blk_d;
            pos_q     <= pos_d;
            rd_addr_q <= mk_addr(blk_d, pos_d);
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The buffer returns data one clock after the address, in step with coeff_valid_q.
  assign coeff_out_o   = coeff_valid_q ? rd_data_i : '0;
  assign coeff_valid_o = coeff_valid_q;
  assign coeff_last_o  = coeff_last_q;
  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign enc_clr_o     = enc_clr_q;
  assign bits_valid_o  = bv_q[ENC_LAT-1];
  assign bits_last_o   = bl_q[ENC_LAT-1];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign state_o       = state_q;

endmodule
